// File: rtl/xdma_clock_pkg.sv
// Shared constants and helpers for the XDMA core-clock divider.
package xdma_clock_pkg;

  localparam int unsigned DEFAULT_DIV_W  = 8;
  localparam int unsigned DEFAULT_STEP_W = 16;

  // Channel index width: one spare bit so out-of-range indices are representable.
  function automatic int unsigned ch_idx_w(input int unsigned num_ch);
    return $clog2(num_ch) + 1;
  endfunction

  // A half-period of zero would never hit its boundary; treat it as one.
  function automatic logic [31:0] clamp_half(input logic [31:0] half);
    return (half == 32'd0) ? 32'd1 : half;
  endfunction

endpackage

// File: rtl/xdma_clock_div_ch.sv
// One divided-clock channel: phase counter, run state, half-period with a single
// pending update slot. Optional step counter when XDMA_CLOCK_STEP_EN is defined.
module xdma_clock_div_ch
  import xdma_clock_pkg::*;
#(
  parameter int unsigned DIV_W      = DEFAULT_DIV_W,
`ifdef XDMA_CLOCK_STEP_EN
  parameter int unsigned STEP_W     = DEFAULT_STEP_W,
`endif
  parameter int unsigned RESET_HALF = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              cfg_wr,
  input  logic [DIV_W-1:0]  cfg_half,
`ifdef XDMA_CLOCK_STEP_EN
  input  logic              step_load,
  input  logic [STEP_W-1:0] step_count,
  output logic              step_busy,
`endif
  output logic              pending,
  output logic              apply,
  output logic              core_clock,
  output logic              core_rise
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] half_q, half_d;
  logic [DIV_W-1:0] pend_half_q, pend_half_d;
  logic             run_q, run_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             rise_q, rise_d;
  logic             request;
  logic             boundary;
  logic             low_hi;

  assign boundary   = run_q && (cnt_q == half_q - DIV_W'(1));
  assign low_hi     = boundary && !clk_q;
  // New half-periods only land at the start of a high phase, or immediately when idle.
  assign apply      = pend_q && (!run_q || low_hi);
  assign pending    = pend_q;
  assign core_clock = clk_q;
  assign core_rise  = rise_q;

`ifdef XDMA_CLOCK_STEP_EN
  logic [STEP_W-1:0] remaining_q, remaining_d;

  assign step_busy = (remaining_q != '0);
  assign request   = enable | step_busy;

  // Step budget: reload on request, count down on each rising edge produced.
  always_comb begin
    remaining_d = remaining_q;
    if (step_load && (step_count != '0)) begin
      remaining_d = step_count;
    end else if (rise_d && step_busy) begin
      remaining_d = remaining_q - STEP_W'(1);
    end
  end

  // Step budget register.
  always_ff @(posedge clock) begin
    if (reset) remaining_q <= '0;
    else       remaining_q <= remaining_d;
  end
`else
  assign request = enable;
`endif

  // Phase sequencing, start/stop decisions and half-period update slot.
  always_comb begin
    cnt_d       = cnt_q;
    run_d       = run_q;
    clk_d       = clk_q;
    rise_d      = 1'b0;
    half_d      = half_q;
    pend_d      = pend_q;
    pend_half_d = pend_half_q;

    if (!run_q) begin
      cnt_d = '0;
      clk_d = 1'b0;
      if (request) run_d = 1'b1;
    end else if (boundary) begin
      cnt_d = '0;
      if (clk_q) begin
        clk_d = 1'b0;
      end else if (request) begin
        clk_d  = 1'b1;
        rise_d = 1'b1;
      end else begin
        // Stop only from the low phase so a high pulse is never cut short.
        run_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end

    if (apply) begin
      half_d = pend_half_q;
      pend_d = 1'b0;
    end
    if (cfg_wr) begin
      pend_d      = 1'b1;
      pend_half_d = DIV_W'(clamp_half(32'(cfg_half)));
    end
  end

  // Channel state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q       <= '0;
      run_q       <= 1'b0;
      clk_q       <= 1'b0;
      rise_q      <= 1'b0;
      half_q      <= DIV_W'(RESET_HALF);
      pend_q      <= 1'b0;
      pend_half_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      run_q       <= run_d;
      clk_q       <= clk_d;
      rise_q      <= rise_d;
      half_q      <= half_d;
      pend_q      <= pend_d;
      pend_half_q <= pend_half_d;
    end
  end

endmodule

// File: rtl/xdma_clock_div.sv
// Multi-channel runtime-programmable clock divider for the XDMA co-sim wrapper.
// Optional feature: define XDMA_CLOCK_STEP_EN to add per-channel step (burst) control.
module xdma_clock_div
  import xdma_clock_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DIV_W      = DEFAULT_DIV_W,
`ifdef XDMA_CLOCK_STEP_EN
  parameter int unsigned STEP_W     = DEFAULT_STEP_W,
`endif
  parameter int unsigned RESET_HALF = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             core_clock_enable,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [ch_idx_w(NUM_CH)-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]              cfg_half,
`ifdef XDMA_CLOCK_STEP_EN
  input  logic                          step_valid,
  input  logic [ch_idx_w(NUM_CH)-1:0]   step_ch,
  input  logic [STEP_W-1:0]             step_count,
  output logic [NUM_CH-1:0]             step_busy,
`endif
  output logic [NUM_CH-1:0]             core_clock,
  output logic [NUM_CH-1:0]             core_rise
);

  localparam int unsigned ChW = ch_idx_w(NUM_CH);

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] apply;
  logic [NUM_CH-1:0] cfg_wr;

  // Ready follows the addressed channel's slot; out-of-range writes are taken and dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == ChW'(i)) cfg_ready = ~pending[i] | apply[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign cfg_wr[g] = cfg_valid & cfg_ready & (cfg_ch == ChW'(g));

    xdma_clock_div_ch #(
      .DIV_W      (DIV_W),
`ifdef XDMA_CLOCK_STEP_EN
      .STEP_W     (STEP_W),
`endif
      .RESET_HALF (RESET_HALF)
    ) u_ch (
      .clock      (clock),
      .reset      (reset),
      .enable     (core_clock_enable[g]),
      .cfg_wr     (cfg_wr[g]),
      .cfg_half   (cfg_half),
`ifdef XDMA_CLOCK_STEP_EN
      .step_load  (step_valid & (step_ch == ChW'(g))),
      .step_count (step_count),
      .step_busy  (step_busy[g]),
`endif
      .pending    (pending[g]),
      .apply      (apply[g]),
      .core_clock (core_clock[g]),
      .core_rise  (core_rise[g])
    );
  end

endmodule

// File: tb/tb_xdma_clock_div.sv
// Self-checking bench for xdma_clock_div (NUM_CH=2, DIV_W=8, RESET_HALF=1).
// Expected waveforms are queued per scenario and popped one per cycle at negedge.
module tb_xdma_clock_div;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] core_clock_enable;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_half;
  logic [1:0] core_clock;
  logic [1:0] core_rise;
`ifdef XDMA_CLOCK_STEP_EN
  logic        step_valid;
  logic [1:0]  step_ch;
  logic [15:0] step_count;
  logic [1:0]  step_busy;
`endif

  typedef struct {
    logic [1:0] clk;
    logic [1:0] rise;
    logic       chk_rdy;
    logic       rdy;
    logic [1:0] busy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  xdma_clock_div #(
    .NUM_CH     (2),
    .DIV_W      (8),
`ifdef XDMA_CLOCK_STEP_EN
    .STEP_W     (16),
`endif
    .RESET_HALF (1)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .core_clock_enable (core_clock_enable),
    .cfg_valid         (cfg_valid),
    .cfg_ready         (cfg_ready),
    .cfg_ch            (cfg_ch),
    .cfg_half          (cfg_half),
`ifdef XDMA_CLOCK_STEP_EN
    .step_valid        (step_valid),
    .step_ch           (step_ch),
    .step_count        (step_count),
    .step_busy         (step_busy),
`endif
    .core_clock        (core_clock),
    .core_rise         (core_rise)
  );

  function automatic exp_t mk(input logic [1:0] c, input logic [1:0] r);
    exp_t e;
    e.clk = c; e.rise = r; e.chk_rdy = 1'b0; e.rdy = 1'b0; e.busy = 2'b00;
    return e;
  endfunction

  task automatic idle_inputs();
    core_clock_enable = 2'b00;
    cfg_valid = 1'b0;
    cfg_ch    = 2'd0;
    cfg_half  = 8'd0;
`ifdef XDMA_CLOCK_STEP_EN
    step_valid = 1'b0;
    step_ch    = 2'd0;
    step_count = 16'd0;
`endif
  endtask

  // Returns at a negedge with reset just released; next posedge is cycle 1.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    @(negedge clock);
    reset = 1'b1;
    core_clock_enable = 2'b11;
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd5;
    for (int k = 1; k <= 3; k++) begin
      e = mk(2'b00, 2'b00); e.chk_rdy = 1'b1; e.rdy = 1'b1;
      sb.push_back(e);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      e = sb.pop_front();
      checks++;
      if (core_clock !== e.clk || core_rise !== e.rise) begin
        errors++;
        $display("FAIL reset k=%0d clk=%b rise=%b expected %b/%b", k, core_clock, core_rise,
                 e.clk, e.rise);
      end
      #1;
      checks++;
      if (cfg_ready !== e.rdy) begin
        errors++;
        $display("FAIL reset_ready k=%0d got %b expected %b", k, cfg_ready, e.rdy);
      end
`ifdef XDMA_CLOCK_STEP_EN
      checks++;
      if (step_busy !== 2'b00) begin
        errors++;
        $display("FAIL reset_busy k=%0d got %b expected 00", k, step_busy);
      end
`endif
    end
  endtask

  task automatic test_start();
    exp_t e;
    logic b;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      b = (k % 2 == 0);
      sb.push_back(mk({1'b0, b}, {1'b0, b}));
    end
    core_clock_enable = 2'b01;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      e = sb.pop_front();
      checks++;
      if (core_clock !== e.clk || core_rise !== e.rise) begin
        errors++;
        $display("FAIL start k=%0d clk=%b rise=%b expected %b/%b", k, core_clock, core_rise,
                 e.clk, e.rise);
      end
    end
  endtask

  task automatic test_cfg_running();
    exp_t e;
    logic c0, c1, r1;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      c0 = (k % 2 == 0);
      if (k < 4) begin
        c1 = c0; r1 = c0;
      end else begin
        c1 = ((k - 4) % 6) < 3; r1 = ((k - 4) % 6) == 0;
      end
      e = mk({c1, c0}, {r1, c0});
      e.chk_rdy = (k == 2); e.rdy = 1'b1;
      sb.push_back(e);
    end
    core_clock_enable = 2'b11;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      e = sb.pop_front();
      checks++;
      if (core_clock !== e.clk || core_rise !== e.rise) begin
        errors++;
        $display("FAIL cfg_running k=%0d clk=%b rise=%b expected %b/%b", k, core_clock,
                 core_rise, e.clk, e.rise);
      end
      if (k == 2) begin cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_half = 8'd3; end
      if (k == 3) cfg_valid = 1'b0;
      #1;
      if (e.chk_rdy) begin
        checks++;
        if (cfg_ready !== e.rdy) begin
          errors++;
          $display("FAIL cfg_running_ready k=%0d got %b expected %b", k, cfg_ready, e.rdy);
        end
      end
    end
  endtask

  task automatic test_stop();
    exp_t e;
    logic c, r;
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      c = 1'b0; r = 1'b0;
      if (k >= 6 && k < 18) begin
        c = ((k - 6) % 8) < 4; r = ((k - 6) % 8) == 0;
      end
      sb.push_back(mk({1'b0, c}, {1'b0, r}));
    end
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd4;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      e = sb.pop_front();
      checks++;
      if (core_clock !== e.clk || core_rise !== e.rise) begin
        errors++;
        $display("FAIL stop k=%0d clk=%b rise=%b expected %b/%b", k, core_clock, core_rise,
                 e.clk, e.rise);
      end
      if (k == 1) begin cfg_valid = 1'b0; core_clock_enable = 2'b01; end
      if (k == 15) core_clock_enable = 2'b00;  // mid high phase
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic c, r;
    do_reset();
    for (int k = 1; k <= 28; k++) begin
      c = (k >= 5 && k <= 7) || (k >= 11 && k <= 12) || (k >= 15 && k <= 19) || (k >= 25);
      r = (k == 5) || (k == 11) || (k == 15) || (k == 25);
      e = mk({1'b0, c}, {1'b0, r});
      e.chk_rdy = (k >= 5 && k <= 11);
      e.rdy     = (k == 5) || (k == 10);
      sb.push_back(e);
    end
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd3;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_initial got %b expected 1", cfg_ready);
    end
    for (int k = 1; k <= 28; k++) begin
      @(negedge clock);
      e = sb.pop_front();
      checks++;
      if (core_clock !== e.clk || core_rise !== e.rise) begin
        errors++;
        $display("FAIL b2b k=%0d clk=%b rise=%b expected %b/%b", k, core_clock, core_rise,
                 e.clk, e.rise);
      end
      if (k == 1)  begin cfg_valid = 1'b0; core_clock_enable = 2'b01; end
      if (k == 5)  begin cfg_valid = 1'b1; cfg_half = 8'd2; end
      if (k == 6)  cfg_half = 8'd5;
      if (k == 11) cfg_valid = 1'b0;
      #1;
      if (e.chk_rdy) begin
        checks++;
        if (cfg_ready !== e.rdy) begin
          errors++;
          $display("FAIL b2b_ready k=%0d got %b expected %b", k, cfg_ready, e.rdy);
        end
      end
    end
  endtask

  task automatic test_clamp_and_range();
    exp_t e;
    logic b;
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      b = (k >= 5) && ((k - 5) % 2 == 0);
      e = mk({b, b}, {b, b});
      e.chk_rdy = (k == 2) || (k == 4) || (k == 5); e.rdy = 1'b1;
      sb.push_back(e);
    end
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd3;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      e = sb.pop_front();
      checks++;
      if (core_clock !== e.clk || core_rise !== e.rise) begin
        errors++;
        $display("FAIL clamp_range k=%0d clk=%b rise=%b expected %b/%b", k, core_clock,
                 core_rise, e.clk, e.rise);
      end
      if (k == 1) cfg_valid = 1'b0;
      if (k == 2) begin cfg_valid = 1'b1; cfg_half = 8'd0; end
      if (k == 3) begin cfg_valid = 1'b0; core_clock_enable = 2'b11; end
      if (k == 4) begin cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_half = 8'd7; end
      if (k == 5) begin cfg_valid = 1'b0; cfg_ch = 2'd0; end
      #1;
      if (e.chk_rdy) begin
        checks++;
        if (cfg_ready !== e.rdy) begin
          errors++;
          $display("FAIL clamp_range_ready k=%0d got %b expected %b", k, cfg_ready, e.rdy);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic b;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      if (k <= 4)      b = (k % 2 == 0);
      else if (k <= 6) b = 1'b0;
      else             b = (k % 2 == 1);
      e = mk({1'b0, b}, {1'b0, b});
      e.chk_rdy = (k >= 3 && k <= 5);
      e.rdy     = (k != 4);
      sb.push_back(e);
    end
    core_clock_enable = 2'b01;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      e = sb.pop_front();
      checks++;
      if (core_clock !== e.clk || core_rise !== e.rise) begin
        errors++;
        $display("FAIL reset_mid k=%0d clk=%b rise=%b expected %b/%b", k, core_clock,
                 core_rise, e.clk, e.rise);
      end
      if (k == 3) begin cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd5; end
      if (k == 4) begin cfg_valid = 1'b0; reset = 1'b1; end
      if (k == 5) reset = 1'b0;
      #1;
      if (e.chk_rdy) begin
        checks++;
        if (cfg_ready !== e.rdy) begin
          errors++;
          $display("FAIL reset_mid_ready k=%0d got %b expected %b", k, cfg_ready, e.rdy);
        end
      end
    end
  endtask

`ifdef XDMA_CLOCK_STEP_EN
  task automatic test_step();
    exp_t e;
    logic c, r;
    do_reset();
    for (int k = 1; k <= 22; k++) begin
      c = (k >= 6 && k <= 7) || (k >= 10 && k <= 11) || (k >= 14 && k <= 15);
      r = (k == 6) || (k == 10) || (k == 14);
      e = mk({1'b0, c}, {1'b0, r});
      e.busy = {1'b0, (k >= 3 && k <= 13)};
      sb.push_back(e);
    end
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd2;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clock);
      e = sb.pop_front();
      checks++;
      if (core_clock !== e.clk || core_rise !== e.rise || step_busy !== e.busy) begin
        errors++;
        $display("FAIL step k=%0d clk=%b rise=%b busy=%b expected %b/%b/%b", k, core_clock,
                 core_rise, step_busy, e.clk, e.rise, e.busy);
      end
      if (k == 1) cfg_valid = 1'b0;
      if (k == 2) begin step_valid = 1'b1; step_ch = 2'd0; step_count = 16'd3; end
      if (k == 3) step_valid = 1'b0;
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_start();
    test_cfg_running();
    test_stop();
    test_back_to_back();
    test_clamp_and_range();
    test_reset_mid();
`ifdef XDMA_CLOCK_STEP_EN
    test_step();
`endif
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
